// File: rtl/mx_pkg.sv
// rtl/mx_pkg.sv - shared MX block constants and serializer state encoding
package mx_pkg;
    localparam int MX_EXP_W = 8;
    localparam logic [MX_EXP_W-1:0] MX_NAN_EXP = 8'hff;

    typedef enum logic [1:0] {
        IDLE,
        SCALE,
        DATA
    } ser_state_t;
endpackage

// File: rtl/mxi8_blk_serializer.sv
// rtl/mxi8_blk_serializer.sv - MX int8 block to scale-beat + element-beat stream
// Optional MX_NAN_FLUSH_EN: zero element beats of a NaN (exp==8'hff) block.
module mxi8_blk_serializer
    import mx_pkg::*;
#(
    parameter int bit_width = 8,
    parameter int k         = 32,
    parameter int lanes     = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic signed [bit_width-1:0]  i_mx_vec [k],
    input  logic [MX_EXP_W-1:0]          i_mx_exp,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [lanes*bit_width-1:0]   o_data,
    output logic                         o_is_scale,
    output logic                         o_last
);
    localparam int OW    = lanes * bit_width;
    localparam int BEATS = k / lanes;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    ser_state_t            state;
    logic [k*bit_width-1:0] vec_q;
    logic [MX_EXP_W-1:0]   exp_q;
    logic [CNT_W-1:0]      beat_cnt;
    logic [CNT_W-1:0]      nxt_cnt;
    logic                  take_in;

    // The last-beat transfer frees the buffer in the same cycle, hence the i_ready path.
    assign o_ready = i_rst_n && ((state == IDLE) ||
                                 (state == DATA && o_last && i_ready));
    assign take_in = i_valid && o_ready;
    assign nxt_cnt = beat_cnt + 1'b1;

    function automatic logic [OW-1:0] beat_data(input logic [CNT_W-1:0] b);
`ifdef MX_NAN_FLUSH_EN
        if (exp_q == MX_NAN_EXP) return '0;
`endif
        return vec_q[int'(b)*OW +: OW];
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            vec_q      <= '0;
            exp_q      <= '0;
            beat_cnt   <= '0;
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_is_scale <= 1'b0;
            o_last     <= 1'b0;
        end else begin
            if (take_in) begin
                for (int i = 0; i < k; i++)
                    vec_q[i*bit_width +: bit_width] <= i_mx_vec[i];
                exp_q      <= i_mx_exp;
                state      <= SCALE;
                o_valid    <= 1'b1;
                o_is_scale <= 1'b1;
                o_last     <= 1'b0;
                o_data     <= OW'(i_mx_exp);
            end else begin
                case (state)
                    SCALE: if (i_ready) begin
                        state      <= DATA;
                        beat_cnt   <= '0;
                        o_is_scale <= 1'b0;
                        o_data     <= beat_data('0);
                        o_last     <= (LAST_CNT == '0);
                    end
                    DATA: if (i_ready) begin
                        if (o_last) begin
                            state    <= IDLE;
                            beat_cnt <= '0;
                            o_valid  <= 1'b0;
                            o_last   <= 1'b0;
                            o_data   <= '0;
                        end else begin
                            beat_cnt <= nxt_cnt;
                            o_data   <= beat_data(nxt_cnt);
                            o_last   <= (nxt_cnt == LAST_CNT);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mxi8_blk_serializer.sv
// tb/tb_mxi8_blk_serializer.sv - table-driven bench for mxi8_blk_serializer
module tb_mxi8_blk_serializer;
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_valid = 1'b0;
    logic              o_ready;
    logic signed [7:0] vec [32];
    logic [7:0]        exp_in = '0;
    logic              o_valid;
    logic              i_ready = 1'b0;
    logic [63:0]       o_data;
    logic              o_is_scale;
    logic              o_last;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        rdy;
        logic        valid;
        logic [63:0] data;
        logic        is_scale;
        logic        last;
        logic        ordy;
    } row_t;

    row_t rows [14];

    localparam logic [63:0] B0 = 64'hf7f6f5f4f3f2f1f0;
    localparam logic [63:0] B1 = 64'hfffefdfcfbfaf9f8;
    localparam logic [63:0] B2 = 64'h0706050403020100;
    localparam logic [63:0] B3 = 64'h0f0e0d0c0b0a0908;
`ifdef MX_NAN_FLUSH_EN
    localparam logic [63:0] NAN_BEAT = 64'h0;
`else
    localparam logic [63:0] NAN_BEAT = 64'h5555555555555555;
`endif

    mxi8_blk_serializer dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_mx_vec   (vec),
        .i_mx_exp   (exp_in),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_is_scale (o_is_scale),
        .o_last     (o_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_beat(input string tag, input logic v, input logic [63:0] d,
                              input logic s, input logic l, input logic r);
        check({tag, ".valid"}, 64'(o_valid), 64'(v));
        check({tag, ".data"}, o_data, d);
        check({tag, ".is_scale"}, 64'(o_is_scale), 64'(s));
        check({tag, ".last"}, 64'(o_last), 64'(l));
        check({tag, ".o_ready"}, 64'(o_ready), 64'(r));
    endtask

    task automatic run_rows(input int first, input int count);
        for (int i = first; i < first + count; i++) begin
            @(negedge clk);
            i_valid = 1'b0;
            i_ready = rows[i].rdy;
            #1;
            check_beat($sformatf("row%0d", i), rows[i].valid, rows[i].data,
                       rows[i].is_scale, rows[i].last, rows[i].ordy);
        end
    endtask

    task automatic load_ramp(input logic [7:0] e);
        for (int j = 0; j < 32; j++) vec[j] = 8'(j - 16);
        exp_in = e;
    endtask

    task automatic load_fill(input logic [7:0] e, input logic [7:0] v);
        for (int j = 0; j < 32; j++) vec[j] = v;
        exp_in = e;
    endtask

    task automatic offer_block(input string tag);
        @(negedge clk);
        i_valid = 1'b1;
        i_ready = 1'b1;
        #1;
        check({tag, ".accept_ready"}, 64'(o_ready), 64'd1);
    endtask

    initial begin
        // single block, then 1-0-0-1 backpressure in DATA
        rows[0]  = '{1'b1, 1'b1, 64'h7a, 1'b1, 1'b0, 1'b0};
        rows[1]  = '{1'b1, 1'b1, B0,     1'b0, 1'b0, 1'b0};
        rows[2]  = '{1'b1, 1'b1, B1,     1'b0, 1'b0, 1'b0};
        rows[3]  = '{1'b1, 1'b1, B2,     1'b0, 1'b0, 1'b0};
        rows[4]  = '{1'b1, 1'b1, B3,     1'b0, 1'b1, 1'b1};
        rows[5]  = '{1'b1, 1'b0, 64'h0,  1'b0, 1'b0, 1'b1};
        rows[6]  = '{1'b1, 1'b1, 64'h7a, 1'b1, 1'b0, 1'b0};
        rows[7]  = '{1'b1, 1'b1, B0,     1'b0, 1'b0, 1'b0};
        rows[8]  = '{1'b0, 1'b1, B1,     1'b0, 1'b0, 1'b0};
        rows[9]  = '{1'b0, 1'b1, B1,     1'b0, 1'b0, 1'b0};
        rows[10] = '{1'b1, 1'b1, B1,     1'b0, 1'b0, 1'b0};
        rows[11] = '{1'b1, 1'b1, B2,     1'b0, 1'b0, 1'b0};
        rows[12] = '{1'b1, 1'b1, B3,     1'b0, 1'b1, 1'b1};
        rows[13] = '{1'b1, 1'b0, 64'h0,  1'b0, 1'b0, 1'b1};

        load_fill(8'h00, 8'h00);
        #12;
        check_beat("reset", 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_beat("post_reset", 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);

        load_ramp(8'h7a);
        offer_block("single");
        run_rows(0, 6);

        load_ramp(8'h7a);
        offer_block("bp");
        run_rows(6, 8);

        // back-to-back: A held until accepted, then B offered while A drains
        load_fill(8'h10, 8'h0a);
        offer_block("b2b_a");
        @(negedge clk);
        load_fill(8'h11, 8'h0b);
        #1;
        check_beat("a_scale", 1'b1, 64'h10, 1'b1, 1'b0, 1'b0);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            #1;
            check_beat($sformatf("a_beat%0d", b), 1'b1, {8{8'h0a}}, 1'b0, b == 3, b == 3);
        end
        @(negedge clk);
        i_valid = 1'b0;
        #1;
        check_beat("b_scale", 1'b1, 64'h11, 1'b1, 1'b0, 1'b0);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            #1;
            check_beat($sformatf("b_beat%0d", b), 1'b1, {8{8'h0b}}, 1'b0, b == 3, b == 3);
        end
        @(negedge clk);
        #1;
        check_beat("b_done", 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);

        load_fill(8'hff, 8'h55);
        offer_block("nan");
        @(negedge clk);
        i_valid = 1'b0;
        #1;
        check_beat("nan_scale", 1'b1, 64'hff, 1'b1, 1'b0, 1'b0);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            #1;
            check_beat($sformatf("nan_beat%0d", b), 1'b1, NAN_BEAT, 1'b0, b == 3, b == 3);
        end

        // reset asserted asynchronously while the 2nd element beat is on the bus
        load_ramp(8'h7a);
        offer_block("rst_mid");
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_mid.beat1", o_data, B1);
        #1;
        rst_n = 1'b0;
        #1;
        check_beat("rst_mid.async", 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check_beat($sformatf("rst_idle%0d", c), 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        end
        load_fill(8'h22, 8'h01);
        offer_block("after_rst");
        @(negedge clk);
        i_valid = 1'b0;
        #1;
        check_beat("after_rst_scale", 1'b1, 64'h22, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check_beat("after_rst_beat0", 1'b1, {8{8'h01}}, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mxi8_blk_serializer.md
# mxi8_blk_serializer

Downstream stage of `conv_bf16tomxi8`. It accepts one complete MX int8 block per handshake: a shared 8-bit exponent plus `k` signed elements. It streams the block onto a narrow valid/ready bus as one scale beat followed by `k/lanes` element beats. The block is fully registered, so the wide converter output is decoupled from the narrow memory/interconnect path.

## Interface
Parameters:
- `bit_width`, 8: element width in bits, signed two's complement.
- `k`, 32: elements per block; must be a multiple of `lanes`.
- `lanes`, 8: elements per output beat; `lanes*bit_width` must be ≥ 8.

Ports:
- `i_clk`, in, 1: clock, rising edge.
- `i_rst_n`, in, 1: asynchronous active-low reset.
- `i_valid`, in, 1: an input block is present.
- `o_ready`, out, 1: the block accepts an input block this cycle.
- `i_mx_vec`, in, `[k]` × `bit_width` signed: block elements.
- `i_mx_exp`, in, 8: shared exponent; 8'hff means NaN block.
- `o_valid`, out, 1: an output beat is present.
- `i_ready`, in, 1: the downstream consumer takes the beat.
- `o_data`, out, `lanes*bit_width`: beat payload.
- `o_is_scale`, out, 1: the current beat is the scale beat.
- `o_last`, out, 1: the current beat is the final beat of the block.

## Operation
- Handshakes:
  - An input transfer occurs when `i_valid && o_ready`.
  - An output transfer occurs when `o_valid && i_ready`.
- Capture: on an input transfer, `i_mx_vec` and `i_mx_exp` are registered into an internal block buffer. Nothing is read from the input ports after that edge.
- FSM:
  - IDLE: `o_valid`=0, `o_ready`=1. An input transfer moves to SCALE.
  - SCALE: `o_valid`=1, `o_is_scale`=1, `o_data` = {zeros, exp[7:0]}. An output transfer moves to DATA with `beat_cnt`=0.
  - DATA: `o_valid`=1. Lane `l` of beat `b` carries element `b*lanes+l` at bits `[l*bit_width +: bit_width]`. Each output transfer increments `beat_cnt`. `o_last` = (`beat_cnt == k/lanes-1`).
- Last-beat exit from DATA:
  - The last-beat output transfer goes to IDLE, or to SCALE if a new input transfer happens in the same cycle.
  - `o_ready` = (state==IDLE) || (state==DATA && `o_last` && `i_ready`). This is a combinational path from `i_ready` to `o_ready`, and it is intended.
- Backpressure: while `o_valid && !i_ready`, `o_data`, `o_is_scale` and `o_last` hold stable.
- `o_valid` never drops without a transfer, except on reset.
- Elements are forwarded bit-exact; no arithmetic is applied apart from the NaN flush in Configuration.

## Timing
- Reset, asserted asynchronously:
  - State = IDLE; `o_valid`=0, `o_data`=0, `o_is_scale`=0, `o_last`=0, `beat_cnt`=0, buffer cleared.
  - `o_ready`=0 while `i_rst_n` is low and 1 in the first cycle after release.
- Latency: block accepted at edge N → scale beat valid after edge N, first element beat one cycle after the scale transfer.
- Throughput: 1 + `k/lanes` beats per block (5 at defaults). With `i_ready` held high, blocks stream back-to-back with no idle cycle.
- Reset mid-block: the partial block is discarded. No remaining beats appear after release, and the next beat seen is a scale beat of a newly accepted block.
- `i_valid` while busy (not last-beat transfer): ignored, `o_ready`=0. The upstream must hold the block.

## Configuration
- `MX_NAN_FLUSH_EN` defined: when the captured exp == 8'hff, every element beat outputs `o_data`=0. The scale beat still carries 8'hff.
- `MX_NAN_FLUSH_EN` undefined: elements of a NaN block are forwarded unchanged.

## Structure
- Shared package `mx_pkg`:
  - `MX_EXP_W`=8 and `MX_NAN_EXP`=8'hff.
  - The `ser_state_t` enum {IDLE, SCALE, DATA}.
- No sub-module. Lane selection is an indexed part-select in the single module. `beat_cnt` width is `$clog2(k/lanes)`, minimum 1.

## Test plan
- Single block, exp=8'h7a, element j = j-16, `i_ready`=1 → beats:
  - 8'h7a with `o_is_scale`=1;
  - then 4 beats with elements −16..15 in lane order;
  - `o_last` only on the 4th element beat; total 5 cycles.
- Backpressure: toggle `i_ready` 1-0-0-1 during DATA → `o_data` stable during stall cycles, no beat lost or duplicated.
- Back-to-back: `i_valid` held high with blocks A (exp=8'h10) and B (exp=8'h11) → `o_ready` pulses on A's last-beat transfer, and B's scale beat follows in the next cycle.
- NaN block, exp=8'hff, elements all 8'h55:
  - `MX_NAN_FLUSH_EN` defined → element beats all 0.
  - `MX_NAN_FLUSH_EN` undefined → element beats 0x55 in every lane.
- Reset mid-block: assert `i_rst_n` low during the 2nd element beat → outputs go to 0 immediately, and after release `o_ready`=1 with no stale beats.
